// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI4 write (AW/W/B) and read (AR/R) channel bundle.
//   slave modport  : the memory responder (axi_mem_slave)
//   master modport : the traffic source (write/read masters, testbench)
// lock/cache/prot/qos/user are deliberately absent.
interface axi_mem_slave_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // write address
    logic [ID_W-1:0]     axi_awid;
    logic [ADDR_W-1:0]   axi_awaddr;
    logic [7:0]          axi_awlen;
    logic [2:0]          axi_awsize;
    logic [1:0]          axi_awburst;
    logic                axi_awvalid;
    logic                axi_awready;
    // write data
    logic [DATA_W-1:0]   axi_wdata;
    logic [DATA_W/8-1:0] axi_wstrb;
    logic                axi_wlast;
    logic                axi_wvalid;
    logic                axi_wready;
    // write response
    logic [ID_W-1:0]     axi_bid;
    logic [1:0]          axi_bresp;
    logic                axi_bvalid;
    logic                axi_bready;
    // read address
    logic [ID_W-1:0]     axi_arid;
    logic [ADDR_W-1:0]   axi_araddr;
    logic [7:0]          axi_arlen;
    logic [2:0]          axi_arsize;
    logic [1:0]          axi_arburst;
    logic                axi_arvalid;
    logic                axi_arready;
    // read data
    logic [ID_W-1:0]     axi_rid;
    logic [DATA_W-1:0]   axi_rdata;
    logic [1:0]          axi_rresp;
    logic                axi_rlast;
    logic                axi_rvalid;
    logic                axi_rready;

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder backed by an on-chip word array.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_READ/R_DATA)
// FSMs share one dual-port array; one outstanding transaction per direction.
// Ports:
//   clk   - single rising-edge clock
//   rst   - asynchronous active-high reset (array contents are kept)
//   s_axi - axi_mem_slave_if.slave, full AW/W/B/AR/R channel set
// Build option: AXI_SLV_STRB_EN enables per-byte write strobes; when left
// undefined wstrb is ignored and every accepted beat writes the full word.
module axi_mem_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH          = 1024
) (
    input  logic            clk,
    input  logic            rst,
    axi_mem_slave_if.slave  s_axi
);
    localparam int IDW      = C_S_AXI_ID_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_LSB = $clog2(DW/8);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int HI_LSB   = ADDR_LSB + IDX_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_e;

    // Any address bit above the word index means out of range.
    function automatic logic addr_oor(input logic [AW-1:0] a);
        return |(a >> HI_LSB);
    endfunction

    // Header-level errors; WRAP and reserved bursts are still walked as INCR.
    function automatic logic hdr_err(input logic [AW-1:0] a, input logic [2:0] sz,
                                     input logic [1:0] bu);
        return addr_oor(a) || (sz != 3'(ADDR_LSB)) || bu[1];
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];

    // ---------------- write path ----------------
    w_state_e         w_state_q, w_state_d;
    logic [IDW-1:0]   wid_q, wid_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [7:0]       wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic             wfixed_q, wfixed_d, woor_q, woor_d, werr_q, werr_d;
    logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic             w_fire;

    assign w_fire = s_axi.axi_wvalid & wready_q;

    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        wfixed_d  = wfixed_q;
        woor_d    = woor_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: if (s_axi.axi_awvalid && awready_q) begin
                wid_d     = s_axi.axi_awid;
                widx_d    = s_axi.axi_awaddr[HI_LSB-1:ADDR_LSB];
                wlen_d    = s_axi.axi_awlen;
                wbeat_d   = '0;
                wfixed_d  = (s_axi.axi_awburst == 2'b00);
                woor_d    = addr_oor(s_axi.axi_awaddr);
                werr_d    = hdr_err(s_axi.axi_awaddr, s_axi.axi_awsize, s_axi.axi_awburst);
                w_state_d = W_DATA;
            end
            W_DATA: if (w_fire) begin
                // wlast must coincide exactly with beat len; length is from awlen regardless
                if (s_axi.axi_wlast != (wbeat_q == wlen_q)) werr_d = 1'b1;
                if (wbeat_q == wlen_q) begin
                    w_state_d = W_RESP;
                end else begin
                    wbeat_d = wbeat_q + 8'd1;
                    if (!wfixed_q) widx_d = widx_q + IDX_W'(1);
                end
            end
            W_RESP: if (bvalid_q && s_axi.axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        // Handshake outputs are registered decodes of the next state, so
        // awready stays low while in reset and rises on the first edge after.
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wfixed_q  <= 1'b0;
            woor_q    <= 1'b0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wfixed_q  <= wfixed_d;
            woor_q    <= woor_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Array write port: no reset, contents survive rst. Out-of-range beats are dropped.
    always_ff @(posedge clk) begin
        if (w_fire && !woor_q) begin
`ifdef AXI_SLV_STRB_EN
            for (int b = 0; b < DW/8; b++)
                if (s_axi.axi_wstrb[b]) mem[widx_q][b*8 +: 8] <= s_axi.axi_wdata[b*8 +: 8];
`else
            mem[widx_q] <= s_axi.axi_wdata;
`endif
        end
    end

`ifndef AXI_SLV_STRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^s_axi.axi_wstrb;
`endif

    // ---------------- read path ----------------
    r_state_e         r_state_q, r_state_d;
    logic [IDW-1:0]   rid_q, rid_d;
    logic [IDX_W-1:0] ridx_q, ridx_d, ridx_nxt;
    logic [7:0]       rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic             rfixed_q, rfixed_d, roor_q, roor_d, rerr_q, rerr_d;
    logic             arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    assign ridx_nxt = rfixed_q ? ridx_q : ridx_q + IDX_W'(1);

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rfixed_d  = rfixed_q;
        roor_d    = roor_q;
        rerr_d    = rerr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: if (s_axi.axi_arvalid && arready_q) begin
                rid_d     = s_axi.axi_arid;
                ridx_d    = s_axi.axi_araddr[HI_LSB-1:ADDR_LSB];
                rlen_d    = s_axi.axi_arlen;
                rbeat_d   = '0;
                rfixed_d  = (s_axi.axi_arburst == 2'b00);
                roor_d    = addr_oor(s_axi.axi_araddr);
                rerr_d    = hdr_err(s_axi.axi_araddr, s_axi.axi_arsize, s_axi.axi_arburst);
                r_state_d = R_READ;
            end
            R_READ: begin
                rdata_d   = roor_q ? '0 : mem[ridx_q];
                rvalid_d  = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: if (rvalid_q && s_axi.axi_rready) begin
                if (rbeat_q == rlen_q) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    // prefetch next word on the accepting edge: one beat per cycle
                    rbeat_d = rbeat_q + 8'd1;
                    ridx_d  = ridx_nxt;
                    rdata_d = roor_q ? '0 : mem[ridx_nxt];
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rfixed_q  <= 1'b0;
            roor_q    <= 1'b0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rfixed_q  <= rfixed_d;
            roor_q    <= roor_d;
            rerr_q    <= rerr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // ---------------- outputs ----------------
    assign s_axi.axi_awready = awready_q;
    assign s_axi.axi_wready  = wready_q;
    assign s_axi.axi_bvalid  = bvalid_q;
    assign s_axi.axi_bid     = wid_q;
    assign s_axi.axi_bresp   = {werr_q, 1'b0};
    assign s_axi.axi_arready = arready_q;
    assign s_axi.axi_rvalid  = rvalid_q;
    assign s_axi.axi_rid     = rid_q;
    assign s_axi.axi_rdata   = rdata_q;
    assign s_axi.axi_rresp   = {rerr_q, 1'b0};
    assign s_axi.axi_rlast   = rvalid_q & (rbeat_q == rlen_q);
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed self-checking bench for axi_mem_slave.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_axi_mem_slave;
    localparam int IDW = 1, AW = 32, DW = 32, DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_mem_slave_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_mem_slave #(
        .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)
    ) dut (.clk(clk), .rst(rst), .s_axi(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [31:0] wdat [16];
    logic [31:0] rdat [16];
    logic        rlst [16];

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [3:0] strb, input int last_at, input int bstall,
                             input logic id, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.axi_awid = id; bus.axi_awaddr = addr; bus.axi_awlen = 8'(len);
        bus.axi_awsize = 3'd2; bus.axi_awburst = burst; bus.axi_awvalid = 1'b1;
        n = 0;
        while (!bus.axi_awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("aw_timeout", 0, 1);
        @(negedge clk);
        bus.axi_awvalid = 1'b0;
        chk("wready_after_aw", bus.axi_wready, 1);
        for (int b = 0; b <= len; b++) begin
            bus.axi_wvalid = 1'b1; bus.axi_wdata = wdat[b]; bus.axi_wstrb = strb;
            bus.axi_wlast = (b == last_at);
            n = 0;
            while (!bus.axi_wready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("w_timeout", 0, 1);
            @(negedge clk);
        end
        bus.axi_wvalid = 1'b0; bus.axi_wlast = 1'b0;
        chk("bvalid_lat", bus.axi_bvalid, 1);
        for (int s = 0; s < bstall; s++) begin
            chk("bvalid_hold", bus.axi_bvalid, 1);
            chk("awready_low", bus.axi_awready, 0);
            @(negedge clk);
        end
        bus.axi_bready = 1'b1;
        n = 0;
        while (!bus.axi_bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("b_timeout", 0, 1);
        resp = bus.axi_bresp;
        chk("bid", bus.axi_bid, id);
        @(negedge clk);
        bus.axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic id, input bit toggle,
                            output logic [1:0] resp, output int ncyc);
        int n, got;
        logic [31:0] hd;
        logic hl;
        bit stalled;
        @(negedge clk);
        bus.axi_arid = id; bus.axi_araddr = addr; bus.axi_arlen = 8'(len);
        bus.axi_arsize = 3'd2; bus.axi_arburst = burst; bus.axi_arvalid = 1'b1;
        n = 0;
        while (!bus.axi_arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ar_timeout", 0, 1);
        @(negedge clk);
        bus.axi_arvalid = 1'b0;
        chk("rvalid_early", bus.axi_rvalid, 0);
        @(negedge clk);
        chk("rvalid_lat", bus.axi_rvalid, 1);
        chk("rid", bus.axi_rid, id);
        got = 0; ncyc = 0; stalled = 0; resp = 2'b11; hd = '0; hl = 1'b0;
        while (got <= len && ncyc < 200) begin
            bus.axi_rready = toggle ? (ncyc % 2 == 1) : 1'b1;
            if (stalled && bus.axi_rvalid) begin
                chk("rdata_hold", bus.axi_rdata, hd);
                chk("rlast_hold", bus.axi_rlast, hl);
            end
            stalled = 0;
            if (bus.axi_rvalid) begin
                if (bus.axi_rready) begin
                    rdat[got] = bus.axi_rdata; rlst[got] = bus.axi_rlast;
                    resp = bus.axi_rresp; got++;
                end else begin
                    stalled = 1; hd = bus.axi_rdata; hl = bus.axi_rlast;
                end
            end
            @(negedge clk);
            ncyc++;
        end
        bus.axi_rready = 1'b0;
        if (got <= len) chk("r_timeout", 0, 1);
        chk("rvalid_drop", bus.axi_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] br, br2, rr;
        logic [31:0] exp_strb;
        int nc, n;
        bus.axi_awid = '0; bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awsize = '0;
        bus.axi_awburst = '0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b0;
        bus.axi_arid = '0; bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arsize = '0;
        bus.axi_arburst = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", bus.axi_awready, 0);
        chk("rst_arready", bus.axi_arready, 0);
        chk("rst_wready", bus.axi_wready, 0);
        chk("rst_bvalid", bus.axi_bvalid, 0);
        chk("rst_rvalid", bus.axi_rvalid, 0);
        chk("rst_rlast", bus.axi_rlast, 0);
        chk("rst_bresp", bus.axi_bresp, 0);
        chk("rst_rresp", bus.axi_rresp, 0);
        chk("rst_rdata", bus.axi_rdata, 0);
        chk("rst_bid", bus.axi_bid, 0);
        chk("rst_rid", bus.axi_rid, 0);
        rst = 1'b0;
        chk("awready_pre_edge", bus.axi_awready, 0);
        @(negedge clk);
        chk("awready_up", bus.axi_awready, 1);
        chk("arready_up", bus.axi_arready, 1);

        // single write then read
        wdat[0] = 32'hDEADBEEF;
        axi_write(32'h10, 0, 2'b01, 4'hF, 0, 0, 1'b1, br);
        chk("single_bresp", br, 2'b00);
        axi_read(32'h10, 0, 2'b01, 1'b1, 1'b0, rr, nc);
        chk("single_rdata", rdat[0], 32'hDEADBEEF);
        chk("single_rlast", rlst[0], 1);
        chk("single_rresp", rr, 2'b00);

        // 16-beat INCR, back-to-back read
        for (int i = 0; i < 16; i++) wdat[i] = 32'(i);
        axi_write(32'h100, 15, 2'b01, 4'hF, 15, 0, 1'b0, br);
        chk("incr16_bresp", br, 2'b00);
        axi_read(32'h100, 15, 2'b01, 1'b0, 1'b0, rr, nc);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("incr16_d%0d", i), rdat[i], 32'(i));
            chk($sformatf("incr16_l%0d", i), rlst[i], (i == 15));
        end
        chk("incr16_cycles", nc, 16);
        chk("incr16_rresp", rr, 2'b00);

        // read backpressure and B backpressure
        axi_read(32'h100, 7, 2'b01, 1'b0, 1'b1, rr, nc);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_d%0d", i), rdat[i], 32'(i));
            chk($sformatf("bp_l%0d", i), rlst[i], (i == 7));
        end
        wdat[0] = 32'h5A5A5A5A;
        axi_write(32'h200, 0, 2'b01, 4'hF, 0, 5, 1'b0, br);
        chk("bstall_bresp", br, 2'b00);

        // errors: out-of-range write dropped (0x1000 aliases word 0)
        wdat[0] = 32'hCAFEF00D;
        axi_write(32'h0, 0, 2'b01, 4'hF, 0, 0, 1'b0, br);
        wdat[0] = 32'h00000055;
        axi_write(32'h1000, 0, 2'b01, 4'hF, 0, 0, 1'b0, br);
        chk("oor_bresp", br, 2'b10);
        axi_read(32'h0, 0, 2'b01, 1'b0, 1'b0, rr, nc);
        chk("oor_unchanged", rdat[0], 32'hCAFEF00D);
        axi_read(32'h1000, 0, 2'b01, 1'b0, 1'b0, rr, nc);
        chk("oor_rdata", rdat[0], 0);
        chk("oor_rresp", rr, 2'b10);
        // early wlast: still 4 beats, SLVERR
        for (int i = 0; i < 4; i++) wdat[i] = 32'h30 + 32'(i);
        axi_write(32'h300, 3, 2'b01, 4'hF, 1, 0, 1'b0, br);
        chk("wlast_bresp", br, 2'b10);
        axi_read(32'h300, 3, 2'b01, 1'b0, 1'b0, rr, nc);
        chk("wlast_beat3", rdat[3], 32'h33);
        chk("wlast_rresp", rr, 2'b00);
        // WRAP read flagged
        axi_read(32'h10, 0, 2'b10, 1'b0, 1'b0, rr, nc);
        chk("wrap_rresp", rr, 2'b10);
        chk("wrap_rdata", rdat[0], 32'hDEADBEEF);

        // strobes
        wdat[0] = 32'h11223344;
        axi_write(32'h20, 0, 2'b01, 4'hF, 0, 0, 1'b0, br);
        wdat[0] = 32'hAABBCCDD;
        axi_write(32'h20, 0, 2'b01, 4'b0101, 0, 0, 1'b0, br);
`ifdef AXI_SLV_STRB_EN
        exp_strb = 32'h11BB33DD;
`else
        exp_strb = 32'hAABBCCDD;
`endif
        axi_read(32'h20, 0, 2'b01, 1'b0, 1'b0, rr, nc);
        chk("strb_rdata", rdat[0], exp_strb);

        // simultaneous AW and AR to one address: read sees the old word
        wdat[0] = 32'h12345678;
        fork
            axi_write(32'h10, 0, 2'b01, 4'hF, 0, 0, 1'b0, br2);
            axi_read(32'h10, 0, 2'b01, 1'b0, 1'b0, rr, nc);
        join
        chk("rbw_old", rdat[0], 32'hDEADBEEF);
        chk("rbw_bresp", br2, 2'b00);
        axi_read(32'h10, 0, 2'b01, 1'b0, 1'b0, rr, nc);
        chk("rbw_new", rdat[0], 32'h12345678);

        // reset during beat 3 of an 8-beat write
        @(negedge clk);
        bus.axi_awaddr = 32'h400; bus.axi_awlen = 8'd7; bus.axi_awsize = 3'd2;
        bus.axi_awburst = 2'b01; bus.axi_awvalid = 1'b1;
        n = 0;
        while (!bus.axi_awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rstw_aw_timeout", 0, 1);
        @(negedge clk);
        bus.axi_awvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.axi_wvalid = 1'b1; bus.axi_wdata = 32'hA0 + 32'(b);
            bus.axi_wstrb = 4'hF; bus.axi_wlast = 1'b0;
            n = 0;
            while (!bus.axi_wready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("rstw_w_timeout", 0, 1);
            @(negedge clk);
        end
        bus.axi_wdata = 32'hA3;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_awready", bus.axi_awready, 0);
        chk("rstw_wready", bus.axi_wready, 0);
        chk("rstw_bvalid", bus.axi_bvalid, 0);
        chk("rstw_rvalid", bus.axi_rvalid, 0);
        bus.axi_wvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        wdat[0] = 32'hB0; wdat[1] = 32'hB1;
        axi_write(32'h500, 1, 2'b01, 4'hF, 1, 0, 1'b1, br);
        chk("rstw_new_bresp", br, 2'b00);
        axi_read(32'h400, 2, 2'b01, 1'b0, 1'b0, rr, nc);
        for (int i = 0; i < 3; i++) chk($sformatf("rstw_keep%0d", i), rdat[i], 32'hA0 + 32'(i));
        axi_read(32'h500, 1, 2'b01, 1'b1, 1'b0, rr, nc);
        chk("rstw_new_d0", rdat[0], 32'hB0);
        chk("rstw_new_d1", rdat[1], 32'hB1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
